shift_add_seq: RTL and testbench
================================

SHIFT_ADD_SEQ -- requirements
Module: shift_add_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width; product width is 2*WIDTH.
REQ-002 Parameter ADD_WAIT, default 2: settle cycles allowed to the shared adder per add; legal range 1..15.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to multiply; sampled only while ready=1.
REQ-006 a  input  WIDTH  multiplicand; captured on the accept edge.
REQ-007 b  input  WIDTH  multiplier; captured on the accept edge.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 done  output  1  single-cycle pulse when product is valid.
REQ-010 product  output  2*WIDTH  result register.

Function
REQ-011 Accept: a rising edge with ready=1 and start=1 loads acc=0, mcand={0,a}, mplier=b, bitcnt=0, and enters TEST.
REQ-012 Start is ignored while ready=0; there is no queuing or abort.
REQ-013 States: IDLE, TEST, WAIT, SHIFT, DONE, encoded in 3 bits; unused codes go to IDLE.
REQ-014 TEST, 1 cycle: mplier[0]=1 goes to WAIT with waitcnt=ADD_WAIT-1; mplier[0]=0 goes to SHIFT.
REQ-015 WAIT: adder inputs are acc and mcand, held constant.
REQ-016 WAIT decrements waitcnt each cycle.
REQ-017 On the WAIT cycle with waitcnt=0, acc takes acc+mcand mod 2^(2*WIDTH) and the state goes to SHIFT.
REQ-018 WAIT lasts exactly ADD_WAIT cycles.
REQ-019 SHIFT, 1 cycle: mcand shifts left 1 with zero fill, mplier shifts right 1 with zero fill, and bitcnt increments.
REQ-020 SHIFT exits to DONE if bitcnt reaches WIDTH, otherwise to TEST.
REQ-021 DONE, 1 cycle: product=acc, done=1, then IDLE.
REQ-022 ready=1 again on the first IDLE cycle.
REQ-023 Latency from the accept edge to done high: 2*WIDTH + ADD_WAIT*popcount(b) + 1 cycles.
REQ-024 product holds its value from DONE until the next DONE and is unchanged during an operation.
REQ-025 done is never high for 2 consecutive cycles.
REQ-026 done and ready are never both high.
REQ-027 Back-to-back: start held high causes acceptance on the first IDLE cycle after DONE.
REQ-028 Arithmetic is unsigned; a=0 or b=0 yields product=0.
REQ-029 The maximum product (2^WIDTH-1)^2 shall not overflow.

Reset
REQ-030 rst_n low asynchronously forces state=IDLE, ready=1, done=0, product=0, and acc, mcand, mplier, bitcnt, waitcnt=0.
REQ-031 Reset in any state, including mid-WAIT, aborts the operation with no done pulse.
REQ-032 The first accept is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro SHIFT_ADD_EARLY_EXIT_EN defined: TEST with mplier=0 goes directly to DONE.
REQ-034 With SHIFT_ADD_EARLY_EXIT_EN, latency = 2*k + ADD_WAIT*popcount(b) + 2 cycles, where k is the index of the highest set bit of b plus 1.
REQ-035 With SHIFT_ADD_EARLY_EXIT_EN, latency for b=0 is 2 cycles.
REQ-036 Macro SHIFT_ADD_EARLY_EXIT_EN undefined: all WIDTH bits are always processed per REQ-023.
REQ-037 product values are identical with and without SHIFT_ADD_EARLY_EXIT_EN.

Verification
REQ-038 WIDTH=8, ADD_WAIT=2, a=0x0D, b=0x05 -> product=0x0041; done 21 cycles after accept (macro off).
REQ-039 a=0xFF, b=0xFF -> product=0xFE01; latency 33 (macro off).
REQ-040 a=0x37, b=0x00, macro on -> product=0x0000, done 2 cycles after accept; macro off -> 17 cycles.
REQ-041 start pulsed while busy, mid-operation -> ignored; the first result is unaffected; ready=0 throughout.
REQ-042 rst_n pulsed low during a WAIT of a=0x12, b=0x03 -> immediate IDLE, product=0, no done.
REQ-042 (cont.) The next operation a=0x12, b=0x03 -> product=0x0036.
REQ-043 start held high for 3 operations a=2,b=3 / a=4,b=5 / a=6,b=7 -> products 6, 20, 42.
REQ-043 (cont.) Each accept occurs on the cycle after the previous done.

Source files
------------

// File: rtl/shift_add_seq.sv
// shift_add_seq
// Sequential unsigned shift-and-add multiplier built around one shared adder.
// The adder is given ADD_WAIT settle cycles for every partial-product add.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    multiply request, sampled only while ready is high
//   a        multiplicand, captured on the accept edge
//   b        multiplier, captured on the accept edge
//   ready    high only while idle
//   done     single-cycle pulse when product is valid
//   product  result register (2*WIDTH bits), held until the next result
//
// Configuration
//   SHIFT_ADD_EARLY_EXIT_EN  when defined, the FSM leaves for DONE as soon as
//                            the remaining multiplier bits are all zero.

module shift_add_seq #(
  parameter int WIDTH    = 8,
  parameter int ADD_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(WIDTH);
  localparam logic [3:0]       WAIT_INIT = 4'(ADD_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [3:0]         waitcnt_q, waitcnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // State and datapath registers; reset clears everything and drops any
  // operation in flight without producing a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      bitcnt_q  <= '0;
      waitcnt_q <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      bitcnt_q  <= bitcnt_d;
      waitcnt_q <= waitcnt_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath logic. The product register is loaded on the
  // transition into DONE, so it is already valid while done is high and
  // stays untouched for the whole of the following operation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    bitcnt_d  = bitcnt_q;
    waitcnt_d = waitcnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d     = '0;
          mcand_d   = {{WIDTH{1'b0}}, a};
          mplier_d  = b;
          bitcnt_d  = '0;
          waitcnt_d = '0;
          state_d   = TEST;
        end
      end

      TEST: begin
`ifdef SHIFT_ADD_EARLY_EXIT_EN
        // No multiplier bits left means acc already holds the product.
        if (mplier_q == '0) begin
          product_d = acc_q;
          state_d   = DONE;
        end else if (mplier_q[0]) begin
          waitcnt_d = WAIT_INIT;
          state_d   = WAIT;
        end else begin
          state_d   = SHIFT;
        end
`else
        if (mplier_q[0]) begin
          waitcnt_d = WAIT_INIT;
          state_d   = WAIT;
        end else begin
          state_d   = SHIFT;
        end
`endif
      end

      // acc and mcand are frozen here so the shared adder can settle; the
      // sum is only committed on the last wait cycle.
      WAIT: begin
        if (waitcnt_q == '0) begin
          acc_d   = acc_q + mcand_q;
          state_d = SHIFT;
        end else begin
          waitcnt_d = waitcnt_q - 4'd1;
        end
      end

      SHIFT: begin
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_d == BITS_LAST) begin
          product_d = acc_q;
          state_d   = DONE;
        end else begin
          state_d   = TEST;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_seq.sv
// tb_shift_add_seq
// Directed bench for shift_add_seq (WIDTH=8, ADD_WAIT=2). Inputs are driven
// and outputs sampled on the falling clock edge. Latency is counted as the
// number of falling edges after the accept edge until done is seen high.

module tb_shift_add_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] product;

  int total;
  int bad;

  shift_add_seq #(
    .WIDTH   (8),
    .ADD_WAIT(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles from the accept edge to done, from the multiplier's bit pattern.
  // With early exit, a multiplier whose top bit is set still walks all bits
  // and leaves through SHIFT, so it keeps the full-length latency.
  function automatic int expLatency(input logic [7:0] bv);
    int pc;
    int k;
    pc = 0;
    k  = 0;
    for (int i = 0; i < 8; i++) begin
      if (bv[i]) begin
        pc++;
        k = i + 1;
      end
    end
`ifdef SHIFT_ADD_EARLY_EXIT_EN
    if (k < 8) return 2 * k + 2 * pc + 2;
`endif
    return 16 + 2 * pc + 1;
  endfunction

  // One comparison: counts it, and on mismatch counts and reports a failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one multiply. Called just after a falling edge; returns just after
  // the falling edge that follows the done cycle (first idle cycle).
  task automatic applyStimulus(input string tag, input logic [7:0] av,
                               input logic [7:0] bv,
                               input logic [15:0] expProd,
                               input bit holdStart, input bit pulseMid);
    int          lat;
    bit          seen;
    bit          busyBad;
    bit          heldBad;
    logic [15:0] prevProd;

    prevProd = product;
    checkOutput({tag, "_readyAtStart"}, 32'(ready), 32'd1);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);

    lat     = 0;
    seen    = 1'b0;
    busyBad = 1'b0;
    heldBad = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !holdStart) start = 1'b0;
      if (pulseMid && lat == 5) begin
        start = 1'b1;
        a     = 8'h77;
        b     = 8'h99;
      end else if (pulseMid && lat == 6) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (ready !== 1'b0) busyBad = 1'b1;
        if (product !== prevProd) heldBad = 1'b1;
      end
    end

    checkOutput({tag, "_doneSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLatency(bv)));
    checkOutput({tag, "_product"}, 32'(product), 32'(expProd));
    checkOutput({tag, "_readyWithDone"}, 32'(ready), 32'd0);
    checkOutput({tag, "_readyLowBusy"}, 32'(busyBad), 32'd0);
    checkOutput({tag, "_productHeld"}, 32'(heldBad), 32'd0);

    @(negedge clk);
    checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_readyAgain"}, 32'(ready), 32'd1);
    checkOutput({tag, "_productKept"}, 32'(product), 32'(expProd));
  endtask

  initial begin
    bit doneBad;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;

    // First accept on the first rising edge after reset release.
    applyStimulus("m0D_05", 8'h0D, 8'h05, 16'h0041, 1'b0, 1'b0);
    applyStimulus("mFF_FF", 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0);
    applyStimulus("m37_00", 8'h37, 8'h00, 16'h0000, 1'b0, 1'b0);
    applyStimulus("m00_A5", 8'h00, 8'hA5, 16'h0000, 1'b0, 1'b0);
    applyStimulus("m81_80", 8'h81, 8'h80, 16'h4080, 1'b0, 1'b0);

    // Start pulsed mid-operation must be ignored.
    applyStimulus("busy0B_06", 8'h0B, 8'h06, 16'h0042, 1'b0, 1'b1);

    // Reset during the WAIT of 0x12*0x03.
    a     = 8'h12;
    b     = 8'h03;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("wait_busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_product", 32'(product), 32'd0);
    doneBad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) doneBad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done !== 1'b0) doneBad = 1'b1;
    end
    checkOutput("abort_noDone", 32'(doneBad), 32'd0);

    applyStimulus("m12_03", 8'h12, 8'h03, 16'h0036, 1'b0, 1'b0);

    // Start held high: each accept on the first idle cycle after done.
    applyStimulus("b2b_1", 8'd2, 8'd3, 16'd6, 1'b1, 1'b0);
    applyStimulus("b2b_2", 8'd4, 8'd5, 16'd20, 1'b1, 1'b0);
    applyStimulus("b2b_3", 8'd6, 8'd7, 16'd42, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
